// File: rtl/nx_instr_arbiter_if.sv
// Bundle between the instruction-RAM arbiter and its three clients: core fetch,
// message-network loader and the single-port RAM itself.
interface nx_instr_arbiter_if #(
  parameter int RAM_ADDR_W = 10,
  parameter int RAM_DATA_W = 32
);
  // Handshakes: a core fetch is taken when i_core_rd_en & !o_core_stall, and
  // the stalled core must hold address and request until then. A loader word
  // is taken when i_load_valid & o_load_ready, and must be held until then.
  logic [RAM_ADDR_W-1:0] i_core_addr;
  logic                  i_core_rd_en;
  logic [RAM_DATA_W-1:0] o_core_rd_data;
  logic                  o_core_stall;
  logic [RAM_DATA_W-1:0] i_load_data;
  logic                  i_load_valid;
  logic                  o_load_ready;
  logic                  i_load_clear;
  logic [RAM_ADDR_W:0]   o_populated;
  logic [RAM_ADDR_W-1:0] o_ram_addr;
  logic                  o_ram_rd_en;
  logic                  o_ram_wr_en;
  logic [RAM_DATA_W-1:0] o_ram_wr_data;
  logic [RAM_DATA_W-1:0] i_ram_rd_data;

  modport slave (
    input  i_core_addr, i_core_rd_en, i_load_data, i_load_valid, i_load_clear,
    input  i_ram_rd_data,
    output o_core_rd_data, o_core_stall, o_load_ready, o_populated,
    output o_ram_addr, o_ram_rd_en, o_ram_wr_en, o_ram_wr_data
  );

  modport master (
    output i_core_addr, i_core_rd_en, i_load_data, i_load_valid, i_load_clear,
    output i_ram_rd_data,
    input  o_core_rd_data, o_core_stall, o_load_ready, o_populated,
    input  o_ram_addr, o_ram_rd_en, o_ram_wr_en, o_ram_wr_data
  );
endinterface

// File: rtl/nx_instr_arbiter.sv
// Arbitrates the single-port instruction RAM between core fetch (default winner)
// and the append-only loader, with a starvation guarantee for the loader.
module nx_instr_arbiter #(
  parameter int RAM_ADDR_W   = 10,
  parameter int RAM_DATA_W   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic               i_clk,
  input logic               i_rst,
  nx_instr_arbiter_if.slave bus
);
  localparam int                  CNT_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]    LP_LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [RAM_ADDR_W:0] LP_DEPTH = {1'b1, {RAM_ADDR_W{1'b0}}};

  logic [RAM_ADDR_W:0]   r_ptr;
  logic [CNT_W-1:0]      r_starve;
  logic                  r_rd_pend;
  logic [RAM_DATA_W-1:0] r_core_rd_data;

  logic w_full;
  logic w_can_load;
  logic w_force;
  logic w_core_gnt;
  logic w_load_gnt;

  // The pointer is one bit wider than the address so "full" is distinguishable
  // from "empty"; there is no wrap, the loader is simply back-pressured.
  assign w_full     = (r_ptr == LP_DEPTH);
  assign w_can_load = bus.i_load_valid & ~w_full & ~bus.i_load_clear;
  assign w_force    = w_can_load & (r_starve >= LP_LIMIT);
  assign w_core_gnt = bus.i_core_rd_en & ~w_force;
  assign w_load_gnt = w_can_load & ~w_core_gnt;

  always_comb begin
    bus.o_core_stall  = bus.i_core_rd_en & ~w_core_gnt;
    bus.o_load_ready  = w_load_gnt;
    bus.o_ram_addr    = '0;
    bus.o_ram_rd_en   = 1'b0;
    bus.o_ram_wr_en   = 1'b0;
    bus.o_ram_wr_data = '0;
    if (w_core_gnt) begin
      bus.o_ram_addr  = bus.i_core_addr;
      bus.o_ram_rd_en = 1'b1;
    end else if (w_load_gnt) begin
      bus.o_ram_addr    = r_ptr[RAM_ADDR_W-1:0];
      bus.o_ram_wr_en   = 1'b1;
      bus.o_ram_wr_data = bus.i_load_data;
    end
  end

  assign bus.o_populated    = r_ptr;
  assign bus.o_core_rd_data = r_core_rd_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr          <= '0;
      r_starve       <= '0;
      r_rd_pend      <= 1'b0;
      r_core_rd_data <= '0;
    end else begin
      r_rd_pend <= w_core_gnt;
      if (r_rd_pend) r_core_rd_data <= bus.i_ram_rd_data;

      if (bus.i_load_clear)  r_ptr <= '0;
      else if (w_load_gnt)   r_ptr <= r_ptr + 1'b1;

      // Counts only cycles where the loader could have written but lost.
      if (w_can_load && !w_load_gnt) begin
        if (r_starve < LP_LIMIT) r_starve <= r_starve + 1'b1;
      end else begin
        r_starve <= '0;
      end
    end
  end
endmodule

// File: tb/tb_nx_instr_arbiter.sv
// Directed table-driven bench for nx_instr_arbiter (8-word RAM, starve limit 4).
module tb_nx_instr_arbiter;
  localparam int AW = 3;
  localparam int DW = 32;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  nx_instr_arbiter_if #(.RAM_ADDR_W(AW), .RAM_DATA_W(DW)) bus ();

  nx_instr_arbiter #(.RAM_ADDR_W(AW), .RAM_DATA_W(DW), .STARVE_LIMIT(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          c_en;
    logic [AW-1:0] c_addr;
    logic          l_v;
    logic [DW-1:0] l_d;
    logic          clr;
    logic [DW-1:0] ram;
    logic          stall;
    logic          ready;
    logic          rd_en;
    logic          wr_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [AW:0]   pop;
    logic [DW-1:0] crd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic c_en, input logic [AW-1:0] c_addr,
                              input logic l_v, input logic [DW-1:0] l_d,
                              input logic clr, input logic [DW-1:0] ram,
                              input logic stall, input logic ready,
                              input logic rd_en, input logic wr_en,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                              input logic [AW:0] pop, input logic [DW-1:0] crd);
    vec_t v;
    v.c_en = c_en; v.c_addr = c_addr; v.l_v = l_v; v.l_d = l_d; v.clr = clr;
    v.ram = ram; v.stall = stall; v.ready = ready; v.rd_en = rd_en;
    v.wr_en = wr_en; v.addr = addr; v.wd = wd; v.pop = pop; v.crd = crd;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic c_en, input logic [AW-1:0] c_addr, input logic l_v,
                       input logic [DW-1:0] l_d, input logic clr, input logic [DW-1:0] ram);
    bus.i_core_rd_en  = c_en;
    bus.i_core_addr   = c_addr;
    bus.i_load_valid  = l_v;
    bus.i_load_data   = l_d;
    bus.i_load_clear  = clr;
    bus.i_ram_rd_data = ram;
  endtask

  task automatic check_outs(input string tag, input logic stall, input logic ready,
                            input logic rd_en, input logic wr_en, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd, input logic [AW:0] pop,
                            input logic [DW-1:0] crd);
    chk({tag, " stall"},    DW'(bus.o_core_stall),   DW'(stall));
    chk({tag, " ready"},    DW'(bus.o_load_ready),   DW'(ready));
    chk({tag, " rd_en"},    DW'(bus.o_ram_rd_en),    DW'(rd_en));
    chk({tag, " wr_en"},    DW'(bus.o_ram_wr_en),    DW'(wr_en));
    chk({tag, " ram_addr"}, DW'(bus.o_ram_addr),     DW'(addr));
    chk({tag, " wr_data"},  bus.o_ram_wr_data,       wd);
    chk({tag, " populated"},DW'(bus.o_populated),    DW'(pop));
    chk({tag, " rd_data"},  bus.o_core_rd_data,      crd);
  endtask

  localparam logic [DW-1:0] BEEF = 32'hDEADBEEF;
  localparam logic [DW-1:0] C1   = 32'hC1C1C1C1;
  localparam logic [DW-1:0] C2   = 32'hC2C2C2C2;
  localparam logic [DW-1:0] F1   = 32'hF1F1F1F1;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    // Load three words, then a single core read with 2-cycle read latency.
    add(0,0,1,32'hA0,0,0,   0,1,0,1,0,32'hA0,0,0);
    add(0,0,1,32'hA1,0,0,   0,1,0,1,1,32'hA1,1,0);
    add(0,0,1,32'hA2,0,0,   0,1,0,1,2,32'hA2,2,0);
    add(0,0,0,0,0,0,        0,0,0,0,0,0,3,0);
    add(1,5,0,0,0,0,        0,0,1,0,5,0,3,0);
    add(0,0,0,0,0,BEEF,     0,0,0,0,0,0,3,0);
    add(0,0,0,0,0,0,        0,0,0,0,0,0,3,BEEF);
    // Core streaming against a waiting loader: 4 core wins, then forced load.
    add(1,1,1,32'hB0,0,C1,  0,0,1,0,1,0,3,BEEF);
    add(1,1,1,32'hB0,0,C1,  0,0,1,0,1,0,3,BEEF);
    add(1,1,1,32'hB0,0,C1,  0,0,1,0,1,0,3,C1);
    add(1,1,1,32'hB0,0,C1,  0,0,1,0,1,0,3,C1);
    add(1,1,1,32'hB0,0,C1,  1,1,0,1,3,32'hB0,3,C1);
    add(1,1,1,32'hB1,0,C2,  0,0,1,0,1,0,4,C1);
    add(0,0,0,0,0,C2,       0,0,0,0,0,0,4,C1);
    add(0,0,0,0,0,0,        0,0,0,0,0,0,4,C2);
    // Fill to 7, then clear with a simultaneous valid word.
    add(0,0,1,32'hD4,0,0,   0,1,0,1,4,32'hD4,4,C2);
    add(0,0,1,32'hD5,0,0,   0,1,0,1,5,32'hD5,5,C2);
    add(0,0,1,32'hD6,0,0,   0,1,0,1,6,32'hD6,6,C2);
    add(0,0,1,32'hD7,1,0,   0,0,0,0,0,0,7,C2);
    for (int k = 0; k < 8; k++) begin
      logic [AW:0] kk;
      kk = (AW+1)'(k);
      add(0,0,1,32'hE0 + DW'(k),0,0, 0,1,0,1,kk[AW-1:0],32'hE0 + DW'(k),kk,C2);
    end
    // Full: loader back-pressured, core still served.
    add(0,0,1,32'hE8,0,0,   0,0,0,0,0,0,8,C2);
    add(1,6,1,32'hE8,0,0,   0,0,1,0,6,0,8,C2);
    add(0,0,1,32'hE8,0,F1,  0,0,0,0,0,0,8,C2);
    add(0,0,1,32'hE8,0,0,   0,0,0,0,0,0,8,F1);
    add(0,0,0,0,1,0,        0,0,0,0,0,0,8,F1);
    add(0,0,0,0,0,0,        0,0,0,0,0,0,0,F1);

    repeat (2) @(negedge clk);
    check_outs("reset", 0,0,0,0,0,0,0,0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].c_en, vecs[i].c_addr, vecs[i].l_v, vecs[i].l_d, vecs[i].clr, vecs[i].ram);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].stall, vecs[i].ready, vecs[i].rd_en,
                 vecs[i].wr_en, vecs[i].addr, vecs[i].wd, vecs[i].pop, vecs[i].crd);
    end

    // Reset with a read in flight and the starve counter at 3.
    @(negedge clk);
    drive(0, 0, 1, 32'h60, 0, 0);
    #1 check_outs("pre_load", 0,1,0,1,0,32'h60,0,F1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, 2, 1, 32'h61, 0, 32'h77);
      #1 check_outs($sformatf("pre_rd%0d", i), 0,0,1,0,2,0,1, (i == 2) ? 32'h77 : F1);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 32'h99);
    #2 rst = 1'b1;
    #1 check_outs("async_rst", 0,0,0,0,0,0,0,0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1, 4, 1, 32'h80, 0, 0);
      #1;
      if (i < 4) check_outs($sformatf("post_rst%0d", i), 0,0,1,0,4,0,0,0);
      else       check_outs("post_rst_force", 1,1,0,1,0,32'h80,0,0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
